// File: rtl/jcm_pkg.sv
// Shared definitions for the Johnson counter monitor.
//   jcm_state_e : monitor FSM states
//   JCM_CODES   : the eight legal 4-bit Johnson codes, indexed by phase
//   jcm_dec_t   : decoded sample {valid, idx}
//   jcm_decode  : code -> {valid, idx}
package jcm_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } jcm_state_e;

  // Element [i] is the code for phase i.
  localparam logic [7:0][3:0] JCM_CODES = {
    4'b0001, 4'b0011, 4'b0111, 4'b1111,
    4'b1110, 4'b1100, 4'b1000, 4'b0000
  };

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } jcm_dec_t;

  function automatic jcm_dec_t jcm_decode(input logic [3:0] code);
    jcm_dec_t r;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (code == JCM_CODES[i]) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder for a 4-bit Johnson counter state.
//   code_i   : raw counter state
//   valid_o  : code is one of the eight legal codes
//   idx_o    : phase index 0..7 (0 when illegal)
//   onehot_o : one-hot of idx_o, all-zero when illegal
module johnson_decode
  import jcm_pkg::*;
(
  input  logic [3:0] code_i,
  output logic       valid_o,
  output logic [2:0] idx_o,
  output logic [7:0] onehot_o
);

  jcm_dec_t dec;

  assign dec      = jcm_decode(code_i);
  assign valid_o  = dec.valid;
  assign idx_o    = dec.idx;
  assign onehot_o = dec.valid ? (8'b1 << dec.idx) : 8'b0;

endmodule

// File: rtl/johnson_monitor.sv
// Monitor for a 4-bit Johnson counter. Decodes each enabled sample, checks
// that successive samples hold or advance by one phase, locks after a run of
// good advances and requests a resync when a locked sequence breaks.
//   in_clk      : clock, rising edge
//   in_clr_n    : asynchronous active-low reset
//   in_en       : sample enable
//   in_q        : counter state
//   in_err_clr  : synchronous clear of the error counter
//   o_idx       : phase index of the last legal sample
//   o_phase     : one-hot phase, zero if the last sample was illegal
//   o_wrap      : pulse on a 7->0 advance (SEARCH/LOCKED only)
//   o_locked    : FSM in LOCKED
//   o_fault     : FSM in FAULT
//   o_resync    : pulse on entry to FAULT, meant to clear the counter
//   o_err_cnt   : saturating count of LOCKED->FAULT events
module johnson_monitor
  import jcm_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             in_clk,
  input  logic             in_clr_n,
  input  logic             in_en,
  input  logic [3:0]       in_q,
  input  logic             in_err_clr,
  output logic [2:0]       o_idx,
  output logic [7:0]       o_phase,
  output logic             o_wrap,
  output logic             o_locked,
  output logic             o_fault,
  output logic             o_resync,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam logic [3:0] LOCK_Q = 4'(LOCK_CNT);

  logic       dec_valid;
  logic [2:0] dec_idx;
  logic [7:0] dec_onehot;

  johnson_decode u_decode (
    .code_i   (in_q),
    .valid_o  (dec_valid),
    .idx_o    (dec_idx),
    .onehot_o (dec_onehot)
  );

  jcm_state_e       state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic             ref_vld_q, ref_vld_d;
  logic [2:0]       ref_idx_q, ref_idx_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic             resync_q, resync_d;
  logic             locked_q, fault_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_inc;
  logic             step_hold, step_adv;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    ref_vld_d = ref_vld_q;
    ref_idx_d = ref_idx_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    resync_d  = 1'b0;
    err_inc   = 1'b0;

    step_hold = ref_vld_q && dec_valid && (dec_idx == ref_idx_q);
    step_adv  = ref_vld_q && dec_valid && (dec_idx == 3'(ref_idx_q + 3'd1));

    if (in_en) begin
      phase_d = dec_onehot;
      if (dec_valid) idx_d = dec_idx;

      unique case (state_q)
        FAULT: begin
          // Only an all-zero sample (the counter's cleared state) ends FAULT.
          if (in_q == 4'b0000) begin
            state_d   = SEARCH;
            run_d     = 4'd0;
            ref_vld_d = 1'b0;
          end
        end
        default: begin
          if (!ref_vld_q) begin
            // First sample only establishes the reference; an illegal one cannot.
            ref_vld_d = dec_valid;
            ref_idx_d = dec_idx;
          end else if (step_adv) begin
            ref_idx_d = dec_idx;
            wrap_d    = (ref_idx_q == 3'd7);
            if (state_q == SEARCH) begin
              if (run_q + 4'd1 == LOCK_Q) begin
                state_d = LOCKED;
                run_d   = 4'd0;
              end else begin
                run_d = run_q + 4'd1;
              end
            end
          end else if (!step_hold) begin
            run_d     = 4'd0;
            ref_vld_d = 1'b0;
            if (state_q == LOCKED) begin
              state_d  = FAULT;
              resync_d = 1'b1;
              err_inc  = 1'b1;
            end
          end
        end
      endcase
    end

    err_d = err_q;
    if (err_inc && (err_q != '1)) err_d = err_q + ERR_W'(1);
    // A clear wins over the old count but not over a same-cycle event.
    if (in_err_clr) err_d = err_inc ? ERR_W'(1) : '0;
  end

  always_ff @(posedge in_clk or negedge in_clr_n) begin
    if (!in_clr_n) begin
      state_q   <= SEARCH;
      run_q     <= 4'd0;
      ref_vld_q <= 1'b0;
      ref_idx_q <= 3'd0;
      idx_q     <= 3'd0;
      phase_q   <= 8'd0;
      wrap_q    <= 1'b0;
      resync_q  <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      ref_vld_q <= ref_vld_d;
      ref_idx_q <= ref_idx_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
      resync_q  <= resync_d;
      locked_q  <= (state_d == LOCKED);
      fault_q   <= (state_d == FAULT);
      err_q     <= err_d;
    end
  end

  assign o_idx     = idx_q;
  assign o_phase   = phase_q;
  assign o_wrap    = wrap_q;
  assign o_locked  = locked_q;
  assign o_fault   = fault_q;
  assign o_resync  = resync_q;
  assign o_err_cnt = err_q;

endmodule

// File: doc/johnson_monitor.md
# johnson_monitor

- Sits directly downstream of the 4-bit Johnson counter and consumes its 4-bit state.
- Decodes the state to a phase index and one-hot phase, and checks that every sampled code is legal and every step is a hold or a +1 advance.
- Locks after a run of good steps and raises a one-cycle resync request when a locked sequence breaks; this request is intended to drive the counter's clear.
- Keeps a saturating error count.

## Interface
Parameters:
- LOCK_CNT, 4: consecutive legal +1 steps required to enter LOCKED (range 1..15)
- ERR_W, 8: width of saturating error counter

Ports:
- in_clk  input  1  clock, all logic on rising edge
- in_clr_n  input  1  reset, asynchronous, active-low
- in_en  input  1  sample enable; in_q ignored when low
- in_q  input  4  counter state, same clock domain
- in_err_clr  input  1  synchronous clear of o_err_cnt
- o_idx  output  3  phase index of last legal sample
- o_phase  output  8  one-hot of o_idx; all-zero if last sample illegal
- o_wrap  output  1  one-cycle pulse on a 7->0 advance
- o_locked  output  1  high in LOCKED
- o_fault  output  1  high in FAULT
- o_resync  output  1  one-cycle pulse on entry to FAULT
- o_err_cnt  output  ERR_W  saturating count of LOCKED->FAULT events

## Operation
- Legal codes, in_q[3:0], map to idx 0..7:
  - 0000=0, 1000=1, 1100=2, 1110=3
  - 1111=4, 0111=5, 0011=6, 0001=7
  - All other 8 codes are illegal.
- Step classification, for an enabled sample against the previous enabled sample:
  - hold: same idx
  - advance: idx = (prev+1) mod 8
  - bad: any other idx, or an illegal code
- Reference sample: the first enabled sample after reset or after leaving FAULT only establishes the reference. It is never counted as a step.
- State machine, reset to SEARCH:
  - SEARCH:
    - advance: run++
    - hold: run unchanged
    - bad: run=0, reference cleared
    - run reaching LOCK_CNT -> LOCKED
  - LOCKED:
    - hold or advance: stay
    - bad -> FAULT, o_err_cnt++ (saturates at all-ones)
  - FAULT:
    - o_resync pulses on the entry cycle only
    - in_q == 0000 sampled -> SEARCH, run=0, reference cleared
    - all other samples ignored
- o_wrap:
  - pulses on an advance 7->0 in SEARCH or LOCKED
  - never pulses on a hold, on the reference sample, or in FAULT
- in_err_clr: zeroes o_err_cnt. If an increment occurs in the same cycle, the result is 1.

## Timing
- All outputs are registered. An enabled sample at edge N is reflected in outputs after edge N, i.e. 1-cycle latency.
- in_en low: no state, run or output change; o_wrap and o_resync are 0.
- Reset (in_clr_n low, asynchronous, any time including mid-run or in FAULT):
  - state=SEARCH, run=0, reference cleared
  - o_idx=0, o_phase=0, o_wrap=0, o_locked=0, o_fault=0, o_resync=0, o_err_cnt=0
- o_locked and o_fault change in the same cycle as the state register.
- o_resync is never asserted for two consecutive cycles.
- Illegal sample: o_phase=0, o_idx holds its previous value.

## Structure
- Package jcm_pkg holds:
  - state enum {SEARCH, LOCKED, FAULT}
  - localparam table of the 8 legal codes
  - function code->{valid, idx}
- Sub-module johnson_decode: combinational in_q -> valid, idx[2:0], one-hot[7:0]. The top instantiates it once.
- Top holds:
  - the FSM
  - run counter (4 bits)
  - reference register (valid + idx)
  - error counter
  - output registers

## Test plan
- Reset, then drive 0000,1000,1100,1110,1111 with in_en=1 and LOCK_CNT=4:
  - o_locked rises one cycle after the 1111 sample
  - o_idx=4, o_phase=8'h10
- Locked, drive 0001 then 0000:
  - o_wrap=1 for exactly one cycle after the 0000 sample
  - o_phase=8'h01
- Locked at idx 2, inject 1111 (skip):
  - o_fault=1, o_resync=1 for one cycle, o_err_cnt=1
  - then drive 0000 -> SEARCH, o_fault=0
- In SEARCH, inject illegal 0101 mid-run:
  - o_phase=0, run resets
  - 4 further legal advances after a new reference are needed to lock
  - no o_resync, o_err_cnt unchanged
- ERR_W=2, force 4 faults:
  - o_err_cnt saturates at 3
  - in_err_clr coincident with a 5th fault gives 1
- Assert in_clr_n low asynchronously mid-LOCKED with in_en toggling: all outputs 0 immediately, state SEARCH.
